mem_port_arbiter: RTL and testbench

Sequential arbiter that shares one single-ported, fixed-latency memory between the instruction-fetch requester (IF stage) and the load/store requester (MEM stage) of the 5-stage RISC-V pipeline. It allows one outstanding access at a time and returns read data or a write acknowledgement to the owning requester. By default it gives priority to data accesses, and a starvation counter guarantees that fetches still make progress. The block sits between the pipeline stage registers and the unified memory, replacing separate instruction and data memory ports.

---
 rtl/riscv_mem_pkg.sv | 22 ++
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/arb_lat_cnt.sv | 31 +++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the unified-memory arbiter.
//   arb_state_e    : arbiter FSM states (idle / waiting on memory)
//   arb_owner_e    : which requester owns the outstanding access
//   DEF_MEM_LAT    : default memory read latency in clock edges
//   DEF_STARVE_MAX : default number of back-to-back data grants tolerated
//                    while a fetch is pending
package riscv_mem_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_e;

    localparam int DEF_MEM_LAT    = 2;
    localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals of the arbiter.
//   slave  : the arbiter's view (takes requests and memory read data,
//            drives grants, responses, memory strobes and busy)
//   master : the surrounding pipeline/memory's view (the reverse)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    // load/store requester
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    // unified memory
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    // status
    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/arb_lat_cnt.sv
// Loadable down-counter that times the memory latency.
//   clk, reset : clock, asynchronous active-high reset
//   load       : reload the counter with load_val (takes priority)
//   load_val   : value loaded on load
//   done       : count is 1, i.e. the current edge is the last of the wait
module arb_lat_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_reg;

    // Counts down to zero and parks there until the next load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign done = (cnt_reg == W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, fixed-latency memory between instruction fetch
// and load/store. One access outstanding at a time; data wins ties unless a
// fetch has waited through STARVE_MAX data grants.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : fetch / load-store request-response ports and memory port
//                (see mem_port_arbiter_if), busy = access outstanding
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);

    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);
    localparam logic [STV_W-1:0] STV_SAT  = STV_W'(STARVE_MAX);

    arb_state_e        state_reg;
    arb_owner_e        owner_reg;
    logic              store_reg;
    logic [STV_W-1:0]  starve_cnt_reg;
    logic [DATA_W-1:0] if_rdata_reg;
    logic [DATA_W-1:0] d_rdata_reg;
    logic              if_rvalid_reg;
    logic              d_rvalid_reg;

    logic arb_open;
    logic pick_if;
    logic gnt_if;
    logic gnt_d;
    logic lat_done;

    // Grants are combinational from the requests while idle. They are held
    // off during reset so nothing is presented to memory that the FSM
    // would not track.
    always_comb begin
        arb_open = (state_reg == ARB_IDLE) && !reset;
        pick_if  = bus.if_req && (!bus.d_req || (starve_cnt_reg == STV_SAT));
        gnt_if   = arb_open && pick_if;
        gnt_d    = arb_open && bus.d_req && !pick_if;
    end

    always_comb begin
        bus.mem_en    = gnt_if || gnt_d;
        bus.mem_we    = gnt_d && bus.d_we;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (gnt_d) begin
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
        end else if (gnt_if) begin
            bus.mem_addr  = bus.if_addr;
        end
    end

    arb_lat_cnt #(.W(LAT_W)) u_lat_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (gnt_if || gnt_d),
        .load_val (LAT_LOAD),
        .done     (lat_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ARB_IDLE;
            owner_reg      <= OWN_IF;
            store_reg      <= 1'b0;
            starve_cnt_reg <= '0;
            if_rdata_reg   <= '0;
            d_rdata_reg    <= '0;
            if_rvalid_reg  <= 1'b0;
            d_rvalid_reg   <= 1'b0;
        end else begin
            if_rvalid_reg <= 1'b0;
            d_rvalid_reg  <= 1'b0;

            case (state_reg)
                ARB_IDLE: begin
                    if (gnt_if || gnt_d) begin
                        owner_reg <= gnt_if ? OWN_IF : OWN_D;
                        store_reg <= gnt_d && bus.d_we;
                        state_reg <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    // mem_rdata is valid on exactly this edge; registering it
                    // keeps memory data off every combinational output path.
                    if (lat_done) begin
                        if (owner_reg == OWN_IF) begin
                            if_rdata_reg  <= bus.mem_rdata;
                            if_rvalid_reg <= 1'b1;
                        end else begin
                            d_rdata_reg   <= store_reg ? '0 : bus.mem_rdata;
                            d_rvalid_reg  <= 1'b1;
                        end
                        state_reg <= ARB_IDLE;
                    end
                end
                default: state_reg <= ARB_IDLE;
            endcase

            // Counts data grants that overtook a waiting fetch.
            if (gnt_if) begin
                starve_cnt_reg <= '0;
            end else if (gnt_d && bus.if_req && (starve_cnt_reg != STV_SAT)) begin
                starve_cnt_reg <= starve_cnt_reg + 1'b1;
            end
        end
    end

    assign bus.if_gnt    = gnt_if;
    assign bus.d_gnt     = gnt_d;
    assign bus.if_rvalid = if_rvalid_reg;
    assign bus.d_rvalid  = d_rvalid_reg;
    assign bus.if_rdata  = if_rdata_reg;
    assign bus.d_rdata   = d_rdata_reg;
    assign bus.busy      = (state_reg == ARB_WAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=4):
// a vector table of single accesses from reset, hand-written sequences for
// back-to-back, starvation and reset-mid-access cases, and a randomized run
// checked against a cycle-count reference model.
module tb_mem_port_arbiter;
    import riscv_mem_pkg::*;

    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   pend_cyc = -1;
    logic [31:0] pend_data = '0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory contents seen by reads (stores are not retained).
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory model: read data is valid only during the cycle LAT edges after
    // the strobe; random junk otherwise so a mistimed capture shows up.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        bus.mem_rdata = (cyc == pend_cyc) ? pend_data : $urandom;
    end
    always @(negedge clk) begin
        if (bus.mem_en === 1'b1 && bus.mem_we === 1'b0) begin
            pend_cyc  = cyc + LAT;
            pend_data = mem_val(bus.mem_addr);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
    endtask

    // Leaves reset asserted at posedge+1; caller releases it and drives.
    task automatic do_reset();
        step();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
    endtask

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        e_if_gnt;
        logic        e_d_gnt;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
    } vec_t;

    localparam int NV = 6;
    vec_t  vecs [NV];
    string vnames [NV];

    // random-phase model state
    int          free_at;
    int          starve;
    int          resp_c;
    logic        resp_if;
    logic [31:0] resp_data;
    logic [31:0] m_if_rdata;
    logic [31:0] m_d_rdata;
    logic        e_busy, e_ig, e_dg, e_we, e_irv, e_drv;
    logic [31:0] e_addr, e_wd;
    string       got;
    int          ng;

    initial begin
        idle_inputs();
        bus.mem_rdata = '0;

        // ---------------- reset state (requests present, reset held) -----
        bus.d_req  = 1'b1;
        bus.if_req = 1'b1;
        step();
        @(negedge clk);
        chk("rst.if_gnt",    bus.if_gnt,    0);
        chk("rst.d_gnt",     bus.d_gnt,     0);
        chk("rst.mem_en",    bus.mem_en,    0);
        chk("rst.mem_addr",  bus.mem_addr,  0);
        chk("rst.busy",      bus.busy,      0);
        chk("rst.if_rvalid", bus.if_rvalid, 0);
        chk("rst.d_rvalid",  bus.d_rvalid,  0);
        chk("rst.if_rdata",  bus.if_rdata,  0);
        chk("rst.d_rdata",   bus.d_rdata,   0);

        // ---------------- vector table: one access from reset -------------
        //              ifr if_addr   dr we d_addr    d_wdata       ig dg we e_addr    e_wdata       e_rdata
        vecs[0] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0};
        vecs[1] = '{1'b1, 32'h10,  1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 32'h10,  32'h0,        32'h0050_0093};
        vecs[2] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h100, 32'h1234,     1'b0, 1'b1, 1'b0, 32'h100, 32'h1234,     32'hC0DE_0100};
        vecs[3] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h20,  32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 32'h20,  32'hDEADBEEF, 32'h0};
        vecs[4] = '{1'b1, 32'h10,  1'b1, 1'b0, 32'h200, 32'h0,        1'b0, 1'b1, 1'b0, 32'h200, 32'h0,        32'hC0DE_0200};
        vecs[5] = '{1'b1, 32'h44,  1'b1, 1'b1, 32'h30,  32'h55,       1'b0, 1'b1, 1'b1, 32'h30,  32'h55,       32'h0};
        vnames = '{"none", "fetch", "load", "store", "both_load", "both_store"};

        for (int i = 0; i < NV; i++) begin
            do_reset();
            reset       = 1'b0;
            bus.if_req  = vecs[i].if_req;
            bus.if_addr = vecs[i].if_addr;
            bus.d_req   = vecs[i].d_req;
            bus.d_we    = vecs[i].d_we;
            bus.d_addr  = vecs[i].d_addr;
            bus.d_wdata = vecs[i].d_wdata;
            @(negedge clk);
            chk({vnames[i], ".if_gnt"},    bus.if_gnt,    vecs[i].e_if_gnt);
            chk({vnames[i], ".d_gnt"},     bus.d_gnt,     vecs[i].e_d_gnt);
            chk({vnames[i], ".mem_en"},    bus.mem_en,    vecs[i].e_if_gnt | vecs[i].e_d_gnt);
            chk({vnames[i], ".mem_we"},    bus.mem_we,    vecs[i].e_we);
            chk({vnames[i], ".mem_addr"},  bus.mem_addr,  vecs[i].e_addr);
            chk({vnames[i], ".mem_wdata"}, bus.mem_wdata, vecs[i].e_wdata);
            for (int k = 1; k <= LAT; k++) begin
                step();
                idle_inputs();
                @(negedge clk);
                chk({vnames[i], ".busy"},   bus.busy,   vecs[i].e_if_gnt | vecs[i].e_d_gnt);
                chk({vnames[i], ".mem_en_wait"}, bus.mem_en, 0);
                chk({vnames[i], ".early_rvalid"}, {31'b0, bus.if_rvalid | bus.d_rvalid}, 0);
            end
            step();
            @(negedge clk);
            chk({vnames[i], ".if_rvalid"}, bus.if_rvalid, vecs[i].e_if_gnt);
            chk({vnames[i], ".d_rvalid"},  bus.d_rvalid,  vecs[i].e_d_gnt);
            chk({vnames[i], ".if_rdata"},  bus.if_rdata,  vecs[i].e_if_gnt ? vecs[i].e_rdata : 32'h0);
            chk({vnames[i], ".d_rdata"},   bus.d_rdata,   vecs[i].e_d_gnt ? vecs[i].e_rdata : 32'h0);
            chk({vnames[i], ".busy_end"},  bus.busy,      0);
            $display("vec %s: if_gnt=%0b d_gnt=%0b addr=0x%08h rdata=0x%08h",
                     vnames[i], vecs[i].e_if_gnt, vecs[i].e_d_gnt, vecs[i].e_addr, vecs[i].e_rdata);
        end

        // ---------------- simultaneous requests, fetch follows on rvalid ---
        do_reset();
        reset       = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h100;
        @(negedge clk);
        chk("sim.T.d_gnt",  bus.d_gnt,  1);
        chk("sim.T.if_gnt", bus.if_gnt, 0);
        step();
        bus.d_req = 1'b0;
        @(negedge clk);
        chk("sim.T1.if_gnt", bus.if_gnt, 0);
        step();
        @(negedge clk);
        chk("sim.T2.if_gnt", bus.if_gnt, 0);
        step();
        @(negedge clk);
        chk("sim.T3.d_rvalid", bus.d_rvalid, 1);
        chk("sim.T3.d_rdata",  bus.d_rdata,  32'hC0DE_0100);
        chk("sim.T3.if_gnt",   bus.if_gnt,   1);
        chk("sim.T3.mem_addr", bus.mem_addr, 32'h10);
        step();
        bus.if_req = 1'b0;
        @(negedge clk);
        step();
        @(negedge clk);
        step();
        @(negedge clk);
        chk("sim.T6.if_rvalid", bus.if_rvalid, 1);
        chk("sim.T6.if_rdata",  bus.if_rdata,  32'h0050_0093);
        $display("seq simultaneous: d then if, if_rdata=0x%08h", bus.if_rdata);

        // ---------------- load then store: store ack clears d_rdata --------
        do_reset();
        reset      = 1'b0;
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h100;
        @(negedge clk);
        step();
        bus.d_req = 1'b0;
        step();
        step();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h20;
        bus.d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("ls.load_rdata", bus.d_rdata,   32'hC0DE_0100);
        chk("ls.st_gnt",     bus.d_gnt,     1);
        chk("ls.st_we",      bus.mem_we,    1);
        chk("ls.st_addr",    bus.mem_addr,  32'h20);
        chk("ls.st_wdata",   bus.mem_wdata, 32'hDEADBEEF);
        step();
        idle_inputs();
        @(negedge clk);
        chk("ls.hold_rdata", bus.d_rdata, 32'hC0DE_0100);
        step();
        step();
        @(negedge clk);
        chk("ls.st_rvalid", bus.d_rvalid, 1);
        chk("ls.st_rdata",  bus.d_rdata,  0);
        $display("seq load_store: store ack d_rdata=0x%08h", bus.d_rdata);

        // ---------------- starvation -------------------------------------
        do_reset();
        reset       = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h40;
        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h80;
        got = "";
        ng  = 0;
        for (int k = 0; k < 60 && ng < 10; k++) begin
            @(negedge clk);
            if (bus.d_gnt && bus.if_gnt) begin
                got = {got, "X"};
                ng++;
            end else if (bus.d_gnt) begin
                got = {got, "D"};
                ng++;
            end else if (bus.if_gnt) begin
                got = {got, "I"};
                ng++;
            end
            step();
        end
        idle_inputs();
        checks++;
        if (got != "DDDDIDDDDI") begin
            errors++;
            $display("FAIL starve_seq: got %s, expected DDDDIDDDDI", got);
        end
        $display("seq starvation: grant order %s", got);

        // ---------------- reset in the middle of a load --------------------
        do_reset();
        reset      = 1'b0;
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h100;
        @(negedge clk);
        chk("rw.T.d_gnt", bus.d_gnt, 1);
        step();
        bus.d_req = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("rw.T1.busy",     bus.busy,     0);
        chk("rw.T1.d_rvalid", bus.d_rvalid, 0);
        chk("rw.T1.mem_en",   bus.mem_en,   0);
        chk("rw.T1.d_rdata",  bus.d_rdata,  0);
        step();
        reset       = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        @(negedge clk);
        chk("rw.T2.if_gnt", bus.if_gnt, 1);
        chk("rw.T2.busy",   bus.busy,   0);
        step();
        bus.if_req = 1'b0;
        @(negedge clk);
        chk("rw.T3.d_rvalid", bus.d_rvalid, 0);
        chk("rw.T3.busy",     bus.busy,     1);
        step();
        @(negedge clk);
        chk("rw.T4.d_rvalid", bus.d_rvalid, 0);
        step();
        @(negedge clk);
        chk("rw.T5.if_rvalid", bus.if_rvalid, 1);
        chk("rw.T5.if_rdata",  bus.if_rdata,  32'h0050_0093);
        chk("rw.T5.d_rvalid",  bus.d_rvalid,  0);
        $display("seq reset_mid_wait: fetch after reset if_rdata=0x%08h", bus.if_rdata);

        // ---------------- randomized run vs. reference model --------------
        do_reset();
        reset      = 1'b0;
        free_at    = 0;
        starve     = 0;
        resp_c     = -1;
        resp_if    = 1'b0;
        resp_data  = '0;
        m_if_rdata = '0;
        m_d_rdata  = '0;
        e_ig       = 1'b0;
        e_dg       = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (c > 0) step();
            // A request stays up until its grant, then may be replaced.
            if (!bus.if_req || e_ig) begin
                bus.if_req  = ($urandom_range(0, 3) != 0);
                bus.if_addr = $urandom & 32'h0000_FFFC;
            end
            if (!bus.d_req || e_dg) begin
                bus.d_req   = ($urandom_range(0, 3) != 0);
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_addr  = $urandom;
                bus.d_wdata = $urandom;
            end
            @(negedge clk);

            // Response due this cycle (before any new grant replaces it).
            e_irv = (c == resp_c) && resp_if;
            e_drv = (c == resp_c) && !resp_if;
            if (e_irv) m_if_rdata = resp_data;
            if (e_drv) m_d_rdata  = resp_data;

            e_busy = (c < free_at);
            e_ig = 1'b0; e_dg = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
            if (!e_busy && (bus.if_req || bus.d_req)) begin
                if (bus.if_req && (!bus.d_req || starve == SMAX)) e_ig = 1'b1;
                else e_dg = 1'b1;
                if (e_ig) begin
                    starve    = 0;
                    e_addr    = bus.if_addr;
                    resp_if   = 1'b1;
                    resp_data = mem_val(bus.if_addr);
                end else begin
                    if (bus.if_req && starve < SMAX) starve++;
                    e_addr    = bus.d_addr;
                    e_we      = bus.d_we;
                    e_wd      = bus.d_wdata;
                    resp_if   = 1'b0;
                    resp_data = bus.d_we ? 32'h0 : mem_val(bus.d_addr);
                end
                free_at = c + LAT + 1;
                resp_c  = c + LAT + 1;
                $display("rnd cyc %0d: grant %s addr=0x%08h we=%0b", c, e_ig ? "if" : "d", e_addr, e_we);
            end

            chk("rnd.if_gnt",    bus.if_gnt,    e_ig);
            chk("rnd.d_gnt",     bus.d_gnt,     e_dg);
            chk("rnd.mem_en",    bus.mem_en,    e_ig | e_dg);
            chk("rnd.mem_we",    bus.mem_we,    e_we);
            chk("rnd.mem_addr",  bus.mem_addr,  e_addr);
            chk("rnd.mem_wdata", bus.mem_wdata, e_wd);
            chk("rnd.busy",      bus.busy,      e_busy);
            chk("rnd.if_rvalid", bus.if_rvalid, e_irv);
            chk("rnd.d_rvalid",  bus.d_rvalid,  e_drv);
            chk("rnd.if_rdata",  bus.if_rdata,  m_if_rdata);
            chk("rnd.d_rdata",   bus.d_rdata,   m_d_rdata);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
